// File: rtl/risc_kgp_pkg.sv
// Shared fetch-side constants: widths, reset PC, PC step, NOP, opcode field.
package risc_kgp_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC_DEF   = 1;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry fetch FIFO; entry 0 is always the head, so head outputs come straight from flops.
module fetch_buffer
  import risc_kgp_pkg::*;
#(
  parameter int unsigned DATA_W = INSTR_W,
  parameter int unsigned PC_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_instr_i,
  input  logic [PC_W-1:0]   push_pc_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_instr_o,
  output logic [PC_W-1:0]   head_pc_o
);

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [PC_W-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;

  // Pop shifts entry 1 forward first; a push then lands in the first free slot.
  always_comb begin
    count_d  = count_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_i && (count_q != 2'd0)) begin
        instr0_d = instr1_q;
        pc0_d    = pc1_q;
        count_d  = count_q - 2'd1;
      end
      if (push_i) begin
        if (count_d == 2'd0) begin
          instr0_d = push_instr_i;
          pc0_d    = push_pc_i;
        end else begin
          instr1_d = push_instr_i;
          pc1_d    = push_pc_i;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      instr0_q <= '0;
      instr1_q <= '0;
      pc0_q    <= '0;
      pc1_q    <= '0;
    end else begin
      count_q  <= count_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
    end
  end

  // Upstream credit logic must never push into a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i) begin
      assert (!(push_i && !pop_i && (count_q == 2'd2)));
    end
  end

  assign count_o      = count_q;
  assign valid_o      = (count_q != 2'd0);
  assign head_instr_o = instr0_q;
  assign head_pc_o    = pc0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-based issue to 1-cycle imem, redirect squash.
// Optional stall_count output enabled by FETCH_STALL_CNT_EN.
module fetch_unit
  import risc_kgp_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned        PC_INC   = PC_INC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]        stall_count,
`endif
  input  logic               instr_ready
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic [1:0]        count;
  logic              accept;
  logic              issue;
  logic              push;
  logic [2:0]        occupancy;

  assign accept    = instr_valid & instr_ready;
  // Slots committed after this cycle's pop: buffered plus the response still in flight.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, accept};
  assign issue     = !reset && !redirect_valid && (occupancy < 3'd2);
  assign push      = inflight_q && !squash_q;

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  // Next PC, in-flight tracking and squash flag; redirect outranks sequential issue.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    squash_d   = redirect_valid;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (issue) begin
      pc_d       = pc_q + ADDR_W'(PC_INC);
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_buffer #(
    .DATA_W (INSTR_W),
    .PC_W   (ADDR_W)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_instr_i (imem_rdata),
    .push_pc_i    (req_pc_q),
    .pop_i        (accept),
    .count_o      (count),
    .valid_o      (instr_valid),
    .head_instr_o (instr),
    .head_pc_o    (instr_pc)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where decode holds off a valid instruction.
  always_comb begin
    stall_d = stall_q;
    if (instr_valid && !instr_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr}, monitor checks accepts.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .PC_INC   (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_count     (stall_count),
`endif
    .instr_ready     (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: mem[a] = a + 100, one cycle latency.
  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_en === 1'b1) imem_rdata <= imem_addr + 32'd100;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_item(input logic [31:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake pops one expectation.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_accept actual_pc=%h actual_instr=%h required=none", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("accept_pc", instr_pc, e.pc);
        chk("accept_instr", instr, e.word);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    step();
    step();
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Streaming and backpressure: pcs 0..7 delivered in order.
    expect_item(32'd0, 32'd100);
    expect_item(32'd1, 32'd101);
    expect_item(32'd2, 32'd102);
    expect_item(32'd3, 32'd103);
    expect_item(32'd4, 32'd104);
    expect_item(32'd5, 32'd105);
    expect_item(32'd6, 32'd106);
    expect_item(32'd7, 32'd107);

    reset = 1'b0;                      // cycle A
    #1;
    chk("first_issue_en", {31'b0, imem_en}, 32'd1);
    chk("lat_valid_c0", {31'b0, instr_valid}, 32'd0);
    step();                            // A+1
    chk("lat_valid_c1", {31'b0, instr_valid}, 32'd0);
    step();                            // A+2
    chk("lat_valid_c2", {31'b0, instr_valid}, 32'd1);
    chk("lat_pc_c2", instr_pc, 32'd0);
    repeat (4) step();                 // A+6
    instr_ready = 1'b0;
    step();                            // A+7
    chk("bp_imem_en_a", {31'b0, imem_en}, 32'd0);
    chk("bp_hold_pc_a", instr_pc, 32'd4);
    chk("bp_hold_instr_a", instr, 32'd104);
    repeat (3) step();                 // A+10
    chk("bp_imem_en_b", {31'b0, imem_en}, 32'd0);
    chk("bp_hold_instr_b", instr, 32'd104);
    step();                            // A+11
`ifdef FETCH_STALL_CNT_EN
    chk("stall_count", stall_count, 32'd5);
`endif
    instr_ready = 1'b1;

    // Redirect to 0x40 with a response arriving and ready low.
    expect_item(32'h40, 32'hA4);
    expect_item(32'h41, 32'hA5);
    expect_item(32'h42, 32'hA6);
    repeat (4) step();                 // A+15
    instr_ready     = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    #1;
    chk("redir_imem_en", {31'b0, imem_en}, 32'd0);
    step();                            // A+16
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #1;
    chk("redir_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_target_addr", imem_addr, 32'h40);
    chk("redir_target_en", {31'b0, imem_en}, 32'd1);
    step();                            // A+17
    chk("redir_valid_c1", {31'b0, instr_valid}, 32'd0);
    step();                            // A+18
    chk("redir_valid_c2", {31'b0, instr_valid}, 32'd1);
    chk("redir_pc_c2", instr_pc, 32'h40);

    // Redirect and accept in the same cycle, ready low afterwards.
    repeat (2) step();                 // A+20
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    #1;
    chk("redir_acc_imem_en", {31'b0, imem_en}, 32'd0);
    step();                            // A+21
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    repeat (2) step();                 // A+23
    chk("redir_acc_valid", {31'b0, instr_valid}, 32'd1);
    chk("redir_acc_pc", instr_pc, 32'h80);
    chk("redir_acc_instr", instr, 32'hE4);

    // Reset mid-stream with the buffer full.
    step();                            // A+24
    reset = 1'b1;
    #1;
    chk("midrst_imem_en", {31'b0, imem_en}, 32'd0);
    step();                            // A+25
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_pc", instr_pc, 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    expect_item(32'd0, 32'd100);
    expect_item(32'd1, 32'd101);
    expect_item(32'd2, 32'd102);
    expect_item(32'hFFFF_FFFF, 32'h0000_0063);
    expect_item(32'h0000_0000, 32'd100);
    expect_item(32'h0000_0001, 32'd101);
    reset       = 1'b0;
    instr_ready = 1'b1;

    // PC wrap via redirect to the top of the address space.
    repeat (4) step();                 // A+29
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    step();                            // A+30
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    chk("wrap_en", {31'b0, imem_en}, 32'd1);
    step();                            // A+31
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);
    repeat (4) step();                 // A+35
    instr_ready = 1'b0;
    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
